// File: rtl/bloom_rx_win.sv
// Sliding MAX_S-byte window over a byte stream arriving 1..IN_BYTES bytes per beat,
// with per-byte valid mask, fill level, packet-boundary clearing and ready/valid on both sides.
module bloom_rx_win #(
    parameter int unsigned  MAX_S        = 8,
    parameter int unsigned  IN_BYTES     = 1,
    parameter bit           CLEAR_ON_EOP = 1'b1,
    localparam int unsigned CW           = $clog2(IN_BYTES + 1),
    localparam int unsigned FW           = $clog2(MAX_S + 1)
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [IN_BYTES-1:0][7:0] data_i,
    input  logic [CW-1:0]            data_cnt_i,
    input  logic                     data_eop_i,
    input  logic                     data_val_i,
    output logic                     data_rdy_o,
    output logic [MAX_S-1:0][7:0]    data_o,
    output logic [MAX_S-1:0]         data_val_o,
    output logic                     data_eop_o,
    output logic                     win_val_o,
    input  logic                     win_rdy_i,
    output logic [FW-1:0]            fill_o
);
    localparam int unsigned DW = MAX_S * 8;

    logic                     accept;
    logic                     clear;
    logic [CW-1:0]            n;
    logic [CW-1:0]            sh;
    logic [IN_BYTES-1:0][7:0] beat_rev;
    logic [MAX_S-1:0]         val_base;
    logic [FW-1:0]            fill_base;
    logic [FW:0]              fill_sum;
    logic [MAX_S-1:0][7:0]    data_nxt;
    logic [MAX_S-1:0]         val_nxt;
    logic [FW-1:0]            fill_nxt;

    assign data_rdy_o = !win_val_o || win_rdy_i;
    assign accept     = data_val_i && data_rdy_o;

    // data_eop_o doubles as the "previous accepted beat closed a packet" flag
    assign clear     = CLEAR_ON_EOP && data_eop_o;
    assign n         = (data_cnt_i > CW'(IN_BYTES)) ? CW'(IN_BYTES) : data_cnt_i;
    assign sh        = CW'(IN_BYTES) - n;
    assign val_base  = clear ? '0 : data_val_o;
    assign fill_base = clear ? '0 : fill_o;

    for (genvar j = 0; j < IN_BYTES; j++) begin : g_rev
        assign beat_rev[j] = data_i[IN_BYTES-1-j];
    end

    // Lane-reversed beat sits below the old window; shifting right by the unused
    // lane count drops lanes >= n and leaves data_i[n-1] at index 0.
    assign data_nxt = DW'({data_o, beat_rev} >> {sh, 3'b000});
    assign val_nxt  = MAX_S'({val_base, {IN_BYTES{1'b1}}} >> sh);

    assign fill_sum = (FW+1)'(fill_base) + (FW+1)'(n);
    assign fill_nxt = (fill_sum > (FW+1)'(MAX_S)) ? FW'(MAX_S) : fill_sum[FW-1:0];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            data_o     <= '0;
            data_val_o <= '0;
            data_eop_o <= 1'b0;
            win_val_o  <= 1'b0;
            fill_o     <= '0;
        end else if (accept) begin
            data_o     <= data_nxt;
            data_val_o <= val_nxt;
            data_eop_o <= data_eop_i;
            win_val_o  <= 1'b1;
            fill_o     <= fill_nxt;
        end else if (win_rdy_i) begin
            win_val_o  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_bloom_rx_win.sv
// Bench for bloom_rx_win: two instances (clear-on-eop on/off) sharing one input stream,
// directed vector table, hand-written hold/reset sequences and a random run against a queue model.
module tb_bloom_rx_win;
    localparam int MAX_S    = 8;
    localparam int IN_BYTES = 4;

    logic                     clk = 1'b0;
    logic                     rst_i = 1'b1;
    logic [IN_BYTES-1:0][7:0] data_i = '0;
    logic [2:0]               data_cnt_i = '0;
    logic                     data_eop_i = 1'b0;
    logic                     data_val_i = 1'b0;
    logic                     win_rdy_i = 1'b1;

    logic                     rdy0, rdy1, deop0, deop1, wval0, wval1;
    logic [MAX_S-1:0][7:0]    dout0, dout1;
    logic [MAX_S-1:0]         dval0, dval1;
    logic [3:0]               fill0, fill1;

    always #5 clk = ~clk;

    bloom_rx_win #(.MAX_S(MAX_S), .IN_BYTES(IN_BYTES), .CLEAR_ON_EOP(1'b1)) u0 (
        .clk_i(clk), .rst_i(rst_i), .data_i(data_i), .data_cnt_i(data_cnt_i),
        .data_eop_i(data_eop_i), .data_val_i(data_val_i), .data_rdy_o(rdy0),
        .data_o(dout0), .data_val_o(dval0), .data_eop_o(deop0), .win_val_o(wval0),
        .win_rdy_i(win_rdy_i), .fill_o(fill0));

    bloom_rx_win #(.MAX_S(MAX_S), .IN_BYTES(IN_BYTES), .CLEAR_ON_EOP(1'b0)) u1 (
        .clk_i(clk), .rst_i(rst_i), .data_i(data_i), .data_cnt_i(data_cnt_i),
        .data_eop_i(data_eop_i), .data_val_i(data_val_i), .data_rdy_o(rdy1),
        .data_o(dout1), .data_val_o(dval1), .data_eop_o(deop1), .win_val_o(wval1),
        .win_rdy_i(win_rdy_i), .fill_o(fill1));

    int nvec = 0;
    int nbad = 0;

    task automatic cmp(input string name, input logic [127:0] act, input logic [127:0] exp);
        nvec++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: byte history newest-first, plus fill counts for both clear modes
    logic [7:0] hist[$];
    int         fill_m0, fill_m1;
    bit         eop_m, wv_m;

    task automatic model_reset();
        hist.delete();
        repeat (MAX_S) hist.push_back(8'h00);
        fill_m0 = 0;
        fill_m1 = 0;
        eop_m   = 1'b0;
        wv_m    = 1'b0;
    endtask

    function automatic int sat(input int x);
        return (x > MAX_S) ? MAX_S : x;
    endfunction

    function automatic logic [7:0] mask_of(input int f);
        return (f >= MAX_S) ? 8'hFF : 8'((1 << f) - 1);
    endfunction

    task automatic model_edge();
        int n;
        if (data_val_i && (!wv_m || win_rdy_i)) begin
            n = (int'(data_cnt_i) > IN_BYTES) ? IN_BYTES : int'(data_cnt_i);
            if (eop_m) fill_m0 = 0;
            for (int k = 0; k < n; k++) hist.push_front(data_i[k]);
            while (hist.size() > MAX_S) void'(hist.pop_back());
            fill_m0 = sat(fill_m0 + n);
            fill_m1 = sat(fill_m1 + n);
            eop_m   = data_eop_i;
            wv_m    = 1'b1;
        end else if (win_rdy_i) begin
            wv_m = 1'b0;
        end
    endtask

    task automatic check_model();
        logic [63:0] exp_d;
        logic        exp_rdy;
        for (int i = 0; i < MAX_S; i++) exp_d[8*i +: 8] = hist[i];
        exp_rdy = !wv_m || win_rdy_i;
        cmp("model_u0", {dout0, dval0, fill0, deop0, wval0, rdy0},
            {exp_d, mask_of(fill_m0), 4'(fill_m0), eop_m, wv_m, exp_rdy});
        cmp("model_u1", {dout1, dval1, fill1, deop1, wval1, rdy1},
            {exp_d, mask_of(fill_m1), 4'(fill_m1), eop_m, wv_m, exp_rdy});
    endtask

    task automatic drive(input bit v, input logic [31:0] d, input logic [2:0] c,
                         input bit e, input bit r);
        data_val_i = v;
        data_i     = d;
        data_cnt_i = c;
        data_eop_i = e;
        win_rdy_i  = r;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_model();
    endtask

    // Called 1 ns after a rising edge; reset asserts and releases mid-cycle
    task automatic pulse_reset();
        data_val_i = 1'b0;
        #2 rst_i = 1'b1;
        #1 model_reset();
        check_model();
        #2 rst_i = 1'b0;
    endtask

    typedef struct {
        bit         rst;
        bit         val;
        logic [31:0] data;
        logic [2:0] cnt;
        bit         eop;
        logic [7:0] e_d0, e_d7, e_mask;
        logic [3:0] e_fill;
        bit         e_eop, e_wv;
        logic [7:0] e_mask1;
        logic [3:0] e_fill1;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input bit rst, input bit val, input logic [31:0] data, input logic [2:0] cnt,
                       input bit eop, input logic [7:0] e_d0, input logic [7:0] e_d7,
                       input logic [7:0] e_mask, input logic [3:0] e_fill, input bit e_eop,
                       input bit e_wv, input logic [7:0] e_mask1, input logic [3:0] e_fill1);
        vec_t v;
        v.rst = rst; v.val = val; v.data = data; v.cnt = cnt; v.eop = eop;
        v.e_d0 = e_d0; v.e_d7 = e_d7; v.e_mask = e_mask; v.e_fill = e_fill;
        v.e_eop = e_eop; v.e_wv = e_wv; v.e_mask1 = e_mask1; v.e_fill1 = e_fill1;
        tbl.push_back(v);
    endtask

    initial begin
        logic [63:0] snap;
        int          f;
        logic [7:0]  kb;

        // single-byte stream 01..0A, then a fresh multi-byte packet and its successor
        add(1, 0, 32'h0, 3'd0, 0, 8'h00, 8'h00, 8'h00, 4'd0, 0, 0, 8'h00, 4'd0);
        for (int k = 1; k <= 10; k++) begin
            f  = (k < MAX_S) ? k : MAX_S;
            kb = 8'(k);
            add(0, 1, {24'hBADCAF, kb}, 3'd1, 0, kb, (k >= 8) ? 8'(k - 7) : 8'h00,
                mask_of(f), 4'(f), 0, 1, mask_of(f), 4'(f));
        end
        add(1, 0, 32'h0,         3'd0, 0, 8'h00, 8'h00, 8'h00, 4'd0, 0, 0, 8'h00, 4'd0);
        add(0, 1, 32'hA3A2A1A0,  3'd4, 0, 8'hA3, 8'h00, 8'h0F, 4'd4, 0, 1, 8'h0F, 4'd4);
        add(0, 1, 32'hEEEEB1B0,  3'd2, 1, 8'hB1, 8'h00, 8'h3F, 4'd6, 1, 1, 8'h3F, 4'd6);
        add(0, 1, 32'h555555C0,  3'd1, 0, 8'hC0, 8'h00, 8'h01, 4'd1, 0, 1, 8'h7F, 4'd7);
        add(0, 0, 32'h12345678,  3'd3, 1, 8'hC0, 8'h00, 8'h01, 4'd1, 0, 0, 8'h7F, 4'd7);
        add(0, 1, 32'h99999999,  3'd0, 0, 8'hC0, 8'h00, 8'h01, 4'd1, 0, 1, 8'h7F, 4'd7);
        add(0, 1, 32'hD3D2D1D0,  3'd7, 0, 8'hD3, 8'hA3, 8'h1F, 4'd5, 0, 1, 8'hFF, 4'd8);
        add(0, 1, 32'h00000000,  3'd0, 1, 8'hD3, 8'hA3, 8'h1F, 4'd5, 1, 1, 8'hFF, 4'd8);
        add(0, 1, 32'h000000E0,  3'd1, 0, 8'hE0, 8'hB0, 8'h01, 4'd1, 0, 1, 8'hFF, 4'd8);

        model_reset();
        #6;
        check_model();
        #1 rst_i = 1'b0;

        foreach (tbl[r]) begin
            if (tbl[r].rst) begin
                pulse_reset();
            end else begin
                drive(tbl[r].val, tbl[r].data, tbl[r].cnt, tbl[r].eop, 1'b1);
                step();
            end
            cmp($sformatf("row%0d_u0", r), {dout0[0], dout0[7], dval0, fill0, deop0, wval0},
                {tbl[r].e_d0, tbl[r].e_d7, tbl[r].e_mask, tbl[r].e_fill, tbl[r].e_eop, tbl[r].e_wv});
            cmp($sformatf("row%0d_u1", r), {dout1[0], dval1, fill1},
                {tbl[r].e_d0, tbl[r].e_mask1, tbl[r].e_fill1});
        end

        // downstream stall with input pending: window frozen, no beat taken
        for (int i = 0; i < MAX_S; i++) snap[8*i +: 8] = hist[i];
        for (int c = 0; c < 5; c++) begin
            drive(1, $urandom, 3'd4, 0, 0);
            step();
            cmp("hold_rdy", {rdy0, rdy1, wval0}, 3'b001);
            cmp("hold_win", dout0, snap);
        end
        for (int c = 0; c < 6; c++) begin
            drive(1, $urandom, 3'($urandom_range(1, 4)), 0, 1);
            step();
            cmp("release_wval", {wval0, wval1}, 2'b11);
        end

        // asynchronous reset mid-packet while a window is presented
        drive(1, 32'h44332211, 3'd4, 0, 1);
        step();
        drive(1, 32'h66550000, 3'd2, 0, 1);
        pulse_reset();
        cmp("rst_async", {wval0, fill0, dval0, dout0, rdy0}, {1'b0, 4'd0, 8'h00, 64'h0, 1'b1});
        drive(1, 32'h000000F1, 3'd1, 0, 1);
        step();
        cmp("post_rst", {dval0, dval1, dout0[0], fill1}, {8'h01, 8'h01, 8'hF1, 4'd1});

        for (int c = 0; c < 2000; c++) begin
            drive($urandom_range(0, 3) != 0, $urandom, 3'($urandom_range(0, 7)),
                  $urandom_range(0, 4) == 0, $urandom_range(0, 3) != 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

endmodule
